// File: rtl/fc_layer_engine.sv
// fc_layer_engine
// Fully-connected layer engine. Each job runs N_CH channels. For each channel the
// engine loads N_IN signed activations over a ready/valid input, then computes N_OUT
// dot products with weights from an external 1-cycle-latency memory. It adds a
// per-neuron bias, rounds, applies optional ReLU and saturates to OUT_W bits. It
// packs PACK results per output word, first result in the MSBs.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                single-cycle job start, honoured only when idle
//   in_valid/in_ready    activation input handshake (in_ready high only while loading)
//   in_data              signed activation
//   w_rd_en/w_addr       weight read strobe and address (j*N_IN+i)
//   w_data               signed weight, one cycle after w_rd_en
//   b_addr/b_data        bias address (neuron j) and signed bias, one cycle latency
//   out_valid/out_ready  packed result handshake
//   out_data             packed results, unused trailing slots are zero
//   busy                 job in progress
//   done                 one-cycle pulse after the final word is accepted
module fc_layer_engine #(
    parameter int IN_W    = 8,
    parameter int W_W     = 8,
    parameter int N_IN    = 64,
    parameter int N_OUT   = 2,
    parameter int N_CH    = 42,
    parameter int ACC_W   = 24,
    parameter int SHIFT   = 10,
    parameter int OUT_W   = 8,
    parameter int RELU_EN = 0,
    parameter int PACK    = 2,
    localparam int WA_W   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int BA_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   in_data,
    output logic                     w_rd_en,
    output logic [WA_W-1:0]          w_addr,
    input  logic signed [W_W-1:0]    w_data,
    output logic [BA_W-1:0]          b_addr,
    input  logic signed [W_W-1:0]    b_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PACK*OUT_W-1:0]    out_data,
    output logic                     busy,
    output logic                     done
);

    localparam int K_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int M_W = $clog2(N_IN + 1);
    localparam int C_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int S_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int P_W = IN_W + W_W;

    // Half an LSB of the shifted result, added before the arithmetic shift so the
    // shift rounds half up instead of truncating toward minus infinity.
    localparam logic signed [ACC_W:0] ROUND =
        (SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_BIAS,
        S_QUANT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                  state;
    logic signed [IN_W-1:0]  act_buf [N_IN];
    logic [K_W-1:0]          load_cnt;
    logic [M_W-1:0]          mac_cnt;
    logic [C_W-1:0]          c_cnt;
    logic [S_W-1:0]          slot;
    logic signed [ACC_W-1:0] acc;
    logic [PACK*OUT_W-1:0]   pack_reg;

    logic [K_W-1:0]          mac_idx;
    logic signed [P_W-1:0]   product;
    logic signed [ACC_W-1:0] product_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W:0]   rounded;
    logic signed [ACC_W:0]   shifted;
    logic signed [OUT_W-1:0] q_result;
    logic [PACK*OUT_W-1:0]   pack_next;
    logic                    last_j;
    logic                    last_c;
    logic                    emit_now;
    logic [WA_W-1:0]         next_base;

    // Datapath: the weight arriving in MAC cycle m belongs to the read issued in
    // cycle m-1, so it pairs with buffer entry m-1. The quantised result is
    // computed from the accumulator as it stands in QUANT.
    always_comb begin
        mac_idx     = (mac_cnt == '0) ? '0 : K_W'(mac_cnt - M_W'(1));
        product     = w_data * act_buf[mac_idx];
        product_ext = {{(ACC_W - P_W){product[P_W-1]}}, product};
        bias_ext    = {{(ACC_W - W_W){b_data[W_W-1]}}, b_data};
        rounded     = {acc[ACC_W-1], acc} + ROUND;
        shifted     = rounded >>> SHIFT;
        if (RELU_EN != 0 && shifted[ACC_W]) begin
            q_result = '0;
        end else if (shifted > SAT_MAX) begin
            q_result = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            q_result = SAT_MIN[OUT_W-1:0];
        end else begin
            q_result = shifted[OUT_W-1:0];
        end
        pack_next = pack_reg;
        for (int s = 0; s < PACK; s++) begin
            if (slot == S_W'(s)) begin
                pack_next[(PACK-1-s)*OUT_W +: OUT_W] = q_result;
            end
        end
        last_j    = (b_addr == BA_W'(N_OUT - 1));
        last_c    = (c_cnt == C_W'(N_CH - 1));
        emit_now  = (slot == S_W'(PACK - 1)) || (last_j && last_c);
        next_base = WA_W'((int'(b_addr) + 1) * N_IN);
    end

    // The activation buffer holds data only and needs no reset.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid) begin
            act_buf[load_cnt] <= in_data;
        end
    end

    // Control FSM. b_addr doubles as the neuron index j. Leaving EMIT (or
    // QUANT when no word is due) picks the next neuron, the next channel or the
    // end of the job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            w_rd_en   <= 1'b0;
            w_addr    <= '0;
            b_addr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            load_cnt  <= '0;
            mac_cnt   <= '0;
            c_cnt     <= '0;
            slot      <= '0;
            acc       <= '0;
            pack_reg  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        c_cnt    <= '0;
                        b_addr   <= '0;
                        load_cnt <= '0;
                        slot     <= '0;
                        pack_reg <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (load_cnt == K_W'(N_IN - 1)) begin
                            in_ready <= 1'b0;
                            load_cnt <= '0;
                            mac_cnt  <= '0;
                            w_rd_en  <= 1'b1;
                            w_addr   <= '0;
                            state    <= S_MAC;
                        end else begin
                            load_cnt <= load_cnt + K_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    mac_cnt <= mac_cnt + M_W'(1);
                    if (mac_cnt < M_W'(N_IN - 1)) begin
                        w_addr <= w_addr + WA_W'(1);
                    end else begin
                        w_rd_en <= 1'b0;
                    end
                    // The first product replaces whatever the previous neuron left.
                    if (mac_cnt == M_W'(1)) begin
                        acc <= product_ext;
                    end else if (mac_cnt != '0) begin
                        acc <= acc + product_ext;
                    end
                    if (mac_cnt == M_W'(N_IN)) begin
                        state <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    acc   <= acc + bias_ext;
                    state <= S_QUANT;
                end
                S_QUANT: begin
                    if (emit_now) begin
                        out_data  <= pack_next;
                        out_valid <= 1'b1;
                        pack_reg  <= '0;
                        slot      <= '0;
                        state     <= S_EMIT;
                    end else begin
                        pack_reg <= pack_next;
                        slot     <= slot + S_W'(1);
                        if (!last_j) begin
                            b_addr  <= b_addr + BA_W'(1);
                            w_addr  <= next_base;
                            w_rd_en <= 1'b1;
                            mac_cnt <= '0;
                            state   <= S_MAC;
                        end else begin
                            b_addr   <= '0;
                            c_cnt    <= c_cnt + C_W'(1);
                            in_ready <= 1'b1;
                            load_cnt <= '0;
                            state    <= S_LOAD;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!last_j) begin
                            b_addr  <= b_addr + BA_W'(1);
                            w_addr  <= next_base;
                            w_rd_en <= 1'b1;
                            mac_cnt <= '0;
                            state   <= S_MAC;
                        end else if (!last_c) begin
                            b_addr   <= '0;
                            c_cnt    <= c_cnt + C_W'(1);
                            in_ready <= 1'b1;
                            load_cnt <= '0;
                            state    <= S_LOAD;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb_fc_layer_engine
// Self-checking bench for fc_layer_engine. Three instances share stimulus:
//   dut      N_IN=4, N_OUT=2, N_CH=2, SHIFT=2, PACK=2, RELU off
//   dut_relu same with RELU on
//   dut_n3   N_IN=4, N_OUT=3, N_CH=1 (zero-padded last word)
// Each instance has its own 1-cycle weight/bias memory model fed from shared
// tables. A vector table holds the activations, per-neuron weights and biases
// and the hand-computed packed words. Hand-written sequences cover the output
// stall and the mid-job reset.
`timescale 1ns/1ps
module tb_fc_layer_engine;

    localparam int N_IN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              out_ready;
    logic signed [7:0] in_data;
    int                sel;

    logic signed [7:0] wt_mem [16];
    logic signed [7:0] bs_mem [4];

    logic              start0, start1, start2;
    logic              in_ready0, w_rd_en0, out_valid0, busy0, done0;
    logic              in_ready1, w_rd_en1, out_valid1, busy1, done1;
    logic              in_ready2, w_rd_en2, out_valid2, busy2, done2;
    logic [2:0]        w_addr0, w_addr1;
    logic [3:0]        w_addr2;
    logic [0:0]        b_addr0, b_addr1;
    logic [1:0]        b_addr2;
    logic signed [7:0] w_data0, w_data1, w_data2;
    logic signed [7:0] b_data0, b_data1, b_data2;
    logic [15:0]       out_data0, out_data1, out_data2;

    logic              cur_in_ready, cur_w_rd_en, cur_out_valid, cur_busy, cur_done;
    logic [15:0]       cur_out_data;
    logic [3:0]        cur_w_addr;
    logic [1:0]        cur_b_addr;

    int                checks = 0;
    int                errors = 0;
    logic [15:0]       got [$];

    typedef struct packed {
        logic [1:0]      sel;
        logic [3:0][7:0] act0;
        logic [3:0][7:0] act1;
        logic [2:0][7:0] wt;
        logic [2:0][7:0] bs;
        logic [1:0]      n_words;
        logic [15:0]     exp0;
        logic [15:0]     exp1;
    } vec_t;

    vec_t vecs [7];

    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);
    assign start2 = start && (sel == 2);

    fc_layer_engine #(
        .IN_W(8), .W_W(8), .N_IN(4), .N_OUT(2), .N_CH(2), .ACC_W(24),
        .SHIFT(2), .OUT_W(8), .RELU_EN(0), .PACK(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .w_rd_en(w_rd_en0), .w_addr(w_addr0), .w_data(w_data0),
        .b_addr(b_addr0), .b_data(b_data0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .busy(busy0), .done(done0)
    );

    fc_layer_engine #(
        .IN_W(8), .W_W(8), .N_IN(4), .N_OUT(2), .N_CH(2), .ACC_W(24),
        .SHIFT(2), .OUT_W(8), .RELU_EN(1), .PACK(2)
    ) dut_relu (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .w_rd_en(w_rd_en1), .w_addr(w_addr1), .w_data(w_data1),
        .b_addr(b_addr1), .b_data(b_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .busy(busy1), .done(done1)
    );

    fc_layer_engine #(
        .IN_W(8), .W_W(8), .N_IN(4), .N_OUT(3), .N_CH(1), .ACC_W(24),
        .SHIFT(2), .OUT_W(8), .RELU_EN(0), .PACK(2)
    ) dut_n3 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .w_rd_en(w_rd_en2), .w_addr(w_addr2), .w_data(w_data2),
        .b_addr(b_addr2), .b_data(b_data2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .busy(busy2), .done(done2)
    );

    // Weight and bias memories with one cycle of read latency.
    always @(posedge clk) begin
        if (w_rd_en0) w_data0 <= wt_mem[w_addr0];
        if (w_rd_en1) w_data1 <= wt_mem[w_addr1];
        if (w_rd_en2) w_data2 <= wt_mem[w_addr2];
        b_data0 <= bs_mem[b_addr0];
        b_data1 <= bs_mem[b_addr1];
        b_data2 <= bs_mem[b_addr2];
    end

    always_comb begin
        cur_in_ready  = in_ready0;
        cur_w_rd_en   = w_rd_en0;
        cur_out_valid = out_valid0;
        cur_busy      = busy0;
        cur_done      = done0;
        cur_out_data  = out_data0;
        cur_w_addr    = {1'b0, w_addr0};
        cur_b_addr    = {1'b0, b_addr0};
        if (sel == 1) begin
            cur_in_ready  = in_ready1;
            cur_w_rd_en   = w_rd_en1;
            cur_out_valid = out_valid1;
            cur_busy      = busy1;
            cur_done      = done1;
            cur_out_data  = out_data1;
            cur_w_addr    = {1'b0, w_addr1};
            cur_b_addr    = {1'b0, b_addr1};
        end else if (sel == 2) begin
            cur_in_ready  = in_ready2;
            cur_w_rd_en   = w_rd_en2;
            cur_out_valid = out_valid2;
            cur_busy      = busy2;
            cur_done      = done2;
            cur_out_data  = out_data2;
            cur_w_addr    = w_addr2;
            cur_b_addr    = b_addr2;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] idle_outputs();
        return {cur_in_ready, cur_w_rd_en, cur_out_valid, cur_busy, cur_done,
                cur_out_data, cur_w_addr, cur_b_addr};
    endfunction

    // Runs one job on the selected instance. The feeder answers in_ready and
    // collects accepted words. stall holds out_ready low for that many cycles
    // from the first out_valid. abort resets the engine during channel 1's MAC.
    // busy_starts pulses start twice mid-job.
    task automatic applyStimulus(input int idx, input vec_t v, input int stall,
                                 input bit abort, input bit busy_starts);
        int ch;
        int k;
        int stall_left;
        bit stall_active;
        bit done_seen;
        string tag;
        tag = $sformatf("job%0d", idx);
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < N_IN; i++) wt_mem[j*N_IN+i] = v.wt[j];
            bs_mem[j] = v.bs[j];
        end
        sel          = int'(v.sel);
        got.delete();
        ch           = 0;
        k            = 0;
        stall_left   = stall;
        stall_active = 1'b0;
        done_seen    = 1'b0;
        out_ready    = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (cur_done) begin
                done_seen = 1'b1;
                break;
            end
            if (abort && ch == 2 && cur_w_rd_en) begin
                rst_n = 1'b0;
                #1;
                checkOutput({tag, "_reset_mid_mac"}, idle_outputs(), 32'h0);
                @(negedge clk);
                rst_n    = 1'b1;
                in_valid = 1'b0;
                return;
            end
            start = busy_starts && (cyc == 3 || cyc == 8);
            if (cur_in_ready && ch < 2) begin
                in_valid = 1'b1;
                in_data  = (ch == 0) ? v.act0[k] : v.act1[k];
                k++;
                if (k == N_IN) begin
                    k = 0;
                    ch++;
                end
            end else begin
                in_valid = 1'b0;
            end
            if (stall_left > 0 && (cur_out_valid || stall_active)) begin
                stall_active = 1'b1;
                out_ready    = 1'b0;
                checkOutput({tag, "_stall_valid"}, cur_out_valid, 1);
                checkOutput({tag, "_stall_data"}, cur_out_data, v.exp0);
                checkOutput({tag, "_stall_rd_en"}, cur_w_rd_en, 0);
                stall_left--;
            end else begin
                out_ready = 1'b1;
                if (cur_out_valid) got.push_back(cur_out_data);
            end
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput({tag, "_done_seen"}, done_seen, 1);
        checkOutput({tag, "_busy_at_done"}, cur_busy, 0);
        checkOutput({tag, "_n_words"}, got.size(), v.n_words);
        if (got.size() > 0) checkOutput({tag, "_word0"}, got[0], v.exp0);
        if (got.size() > 1) checkOutput({tag, "_word1"}, got[1], v.exp1);
        @(negedge clk);
        checkOutput({tag, "_after_done"}, {cur_done, cur_busy}, 2'b00);
    endtask

    initial begin
        // Rounding is (acc + 2) >>> 2, saturation to [-128, 127].
        // all ones, bias 0: acc 4 -> 1
        vecs[0] = '{sel: 2'd0, act0: {4{8'd1}}, act1: {4{8'd1}},
                    wt: {8'd0, 8'd1, 8'd1}, bs: '0,
                    n_words: 2'd2, exp0: 16'h0101, exp1: 16'h0101};
        // acc 6 -> 2; channel 1 acc 2 -> 1 (half rounds up)
        vecs[1] = '{sel: 2'd0, act0: {8'd3, 8'd1, 8'd1, 8'd1}, act1: {8'd0, 8'd0, 8'd1, 8'd1},
                    wt: {8'd0, 8'd1, 8'd1}, bs: '0,
                    n_words: 2'd2, exp0: 16'h0202, exp1: 16'h0101};
        // negated weights: acc -6 -> -1; acc -2 -> 0 (half rounds up)
        vecs[2] = '{sel: 2'd0, act0: {8'd3, 8'd1, 8'd1, 8'd1}, act1: {8'd0, 8'd0, 8'd1, 8'd1},
                    wt: {8'd0, 8'hFF, 8'hFF}, bs: '0,
                    n_words: 2'd2, exp0: 16'hFFFF, exp1: 16'h0000};
        // saturation: 127*127*4 -> 0x7F, 127*-127*4 -> 0x80; channel 1 inputs -128
        vecs[3] = '{sel: 2'd0, act0: {4{8'd127}}, act1: {4{8'h80}},
                    wt: {8'd0, 8'h81, 8'd127}, bs: '0,
                    n_words: 2'd2, exp0: 16'h7F80, exp1: 16'h807F};
        // same on the ReLU instance: negative results clamp to 0
        vecs[4] = '{sel: 2'd1, act0: {4{8'd127}}, act1: {4{8'h80}},
                    wt: {8'd0, 8'h81, 8'd127}, bs: '0,
                    n_words: 2'd2, exp0: 16'h7F00, exp1: 16'h007F};
        // distinct neurons with biases -8 and 4: acc 2 -> 1, 24 -> 6; zeros: -8 -> -2, 4 -> 1
        vecs[5] = '{sel: 2'd0, act0: {8'd4, 8'd3, 8'd2, 8'd1}, act1: '0,
                    wt: {8'd0, 8'd2, 8'd1}, bs: {8'd0, 8'd4, 8'hF8},
                    n_words: 2'd2, exp0: 16'h0106, exp1: 16'hFE01};
        // three neurons, one channel: all 5, last word zero-padded
        vecs[6] = '{sel: 2'd2, act0: {4{8'd5}}, act1: '0,
                    wt: {8'd1, 8'd1, 8'd1}, bs: '0,
                    n_words: 2'd2, exp0: 16'h0505, exp1: 16'h0500};

        for (int i = 0; i < 16; i++) wt_mem[i] = '0;
        for (int i = 0; i < 4; i++) bs_mem[i] = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        sel       = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkOutput($sformatf("reset_inst%0d", s), idle_outputs(), 32'h0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) applyStimulus(v, vecs[v], 0, 1'b0, 1'b0);

        // Output stall of 20 cycles on the first word.
        applyStimulus(7, vecs[5], 20, 1'b0, 1'b0);

        // Reset during channel 1's MAC, then confirm the engine stays quiet.
        applyStimulus(8, vecs[0], 0, 1'b1, 1'b0);
        begin
            logic [31:0] seen;
            seen = '0;
            for (int c = 0; c < 10; c++) begin
                seen = seen | idle_outputs();
                @(negedge clk);
            end
            checkOutput("post_reset_quiet", seen, 32'h0);
        end

        // Full job after the abort, with start pulses while busy.
        applyStimulus(9, vecs[0], 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
